// File: rtl/vernier_sweep_ctrl.sv
// Vernier tap sweep sequencer: steps the tap across [T_MIN, T_MAX], settles,
// averages 2^NAVG_LOG2 captured samples per tap and emits one tagged result.
module vernier_sweep_ctrl #(
    parameter int T_MIN      = 2,
    parameter int T_MAX      = 120,
    parameter int SETTLE_CYC = 16,
    parameter int NAVG_LOG2  = 4,
    parameter int SAMPLE_W   = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [7:0]                    tap_o,
    input  logic [15:0]                   map_pos_i,
    output logic                          cap_req_o,
    input  logic                          cap_ack_i,
    input  logic [SAMPLE_W-1:0]           cap_data_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [7:0]                    res_tap_o,
    output logic [15:0]                   res_pos_o,
    output logic [SAMPLE_W+NAVG_LOG2-1:0] res_sum_o,
    output logic [SAMPLE_W-1:0]           res_mean_o
);

    localparam int ACC_W = SAMPLE_W + NAVG_LOG2;
    localparam int CNT_W = NAVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << NAVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [7:0]       TAP_MIN  = 8'(T_MIN);
    localparam logic [7:0]       TAP_MAX  = 8'(T_MAX);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, EMIT} state_e;

    state_e             state_q, state_d;
    logic [7:0]         tap_q, tap_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [7:0]         res_tap_q, res_tap_d;
    logic [15:0]        res_pos_q, res_pos_d;
    logic [ACC_W-1:0]   res_sum_q, res_sum_d;
    logic               done_q, done_d;

    logic xfer, last_xfer, accept;
    logic [ACC_W-1:0] acc_next;

    assign xfer      = (state_q == CAPTURE) && cap_ack_i;
    assign last_xfer = xfer && (cnt_q == LAST_CNT);
    assign accept    = (state_q == EMIT) && res_ready_i;
    assign acc_next  = acc_q + ACC_W'(cap_data_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // abort beats every transition, including start in IDLE
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i)          state_d = SETTLE;
                SETTLE:  if (set_q == '0)      state_d = CAPTURE;
                CAPTURE: if (last_xfer)        state_d = EMIT;
                EMIT:    if (accept)           state_d = (tap_q == TAP_MAX) ? IDLE : SETTLE;
                default:                       state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        cap_req_o   = (state_q == CAPTURE);
        res_valid_o = (state_q == EMIT);
    end

    always_comb begin
        tap_d     = tap_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        set_d     = set_q;
        res_tap_d = res_tap_q;
        res_pos_d = res_pos_q;
        res_sum_d = res_sum_q;
        done_d    = 1'b0;
        if (abort_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    tap_d = TAP_MIN;
                    acc_d = '0;
                    cnt_d = '0;
                    set_d = SET_LOAD;
                end
                SETTLE: if (set_q != '0) set_d = set_q - SET_W'(1);
                CAPTURE: if (xfer) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_xfer) begin
                        res_tap_d = tap_q;
                        res_pos_d = map_pos_i;
                        res_sum_d = acc_next;
                    end
                end
                EMIT: if (accept) begin
                    if (tap_q == TAP_MAX) begin
                        done_d = 1'b1;
                    end else begin
                        tap_d = tap_q + 8'd1;
                        acc_d = '0;
                        cnt_d = '0;
                        set_d = SET_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tap_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            set_q     <= '0;
            res_tap_q <= '0;
            res_pos_q <= '0;
            res_sum_q <= '0;
            done_q    <= 1'b0;
        end else begin
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            set_q     <= set_d;
            res_tap_q <= res_tap_d;
            res_pos_q <= res_pos_d;
            res_sum_q <= res_sum_d;
            done_q    <= done_d;
        end
    end

    assign done_o     = done_q;
    assign tap_o      = tap_q;
    assign res_tap_o  = res_tap_q;
    assign res_pos_o  = res_pos_q;
    assign res_sum_o  = res_sum_q;
    assign res_mean_o = res_sum_q[ACC_W-1:NAVG_LOG2];

endmodule

// File: tb/tb_vernier_sweep_ctrl.sv
// Bench for vernier_sweep_ctrl: directed sweeps plus a randomized sweep
// checked against a per-tap sample-sum model.
module tb_vernier_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2, abort, cap_ack, res_ready;
    logic [11:0] cap_data;

    logic        busy, done, cap_req, res_valid;
    logic [7:0]  tap, res_tap;
    logic [15:0] map_pos, res_pos, res_sum;
    logic [11:0] res_mean;

    logic        busy_b, done_b, cap_req_b, res_valid_b;
    logic [7:0]  tap_b, res_tap_b;
    logic [15:0] map_pos_b, res_pos_b, res_sum_b;
    logic [11:0] res_mean_b;

    // point map table: 80*tap+10 with two irregular calibration entries
    function automatic logic [15:0] pmap(input logic [7:0] t);
        if (t == 8'd3) return 16'd50;
        if (t == 8'd8) return 16'd130;
        return 16'(80 * int'(t) + 10);
    endfunction

    assign map_pos   = pmap(tap);
    assign map_pos_b = pmap(tap_b);

    vernier_sweep_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .busy_o(busy), .done_o(done), .tap_o(tap), .map_pos_i(map_pos),
        .cap_req_o(cap_req), .cap_ack_i(cap_ack), .cap_data_i(cap_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_tap_o(res_tap),
        .res_pos_o(res_pos), .res_sum_o(res_sum), .res_mean_o(res_mean)
    );

    vernier_sweep_ctrl #(.T_MIN(7), .T_MAX(7)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(abort),
        .busy_o(busy_b), .done_o(done_b), .tap_o(tap_b), .map_pos_i(map_pos_b),
        .cap_req_o(cap_req_b), .cap_ack_i(cap_ack), .cap_data_i(cap_data),
        .res_valid_o(res_valid_b), .res_ready_i(res_ready), .res_tap_o(res_tap_b),
        .res_pos_o(res_pos_b), .res_sum_o(res_sum_b), .res_mean_o(res_mean_b)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    int n, nres, ndone, xf, exp_tap, hit;
    longint acc;

    initial begin
        rst = 1; start = 0; start2 = 0; abort = 0; cap_ack = 0; res_ready = 0; cap_data = 0;
        nx(); nx(); nx();
        chk("reset_a", {busy, done, cap_req, res_valid, tap, res_tap, res_pos, res_sum, res_mean}, 64'd0);
        chk("reset_b", {busy_b, done_b, cap_req_b, res_valid_b, tap_b, res_tap_b, res_pos_b, res_sum_b, res_mean_b}, 64'd0);

        // run into tap 3 capture, then reset mid-sweep
        rst = 0; cap_ack = 1; res_ready = 1; start = 1; cap_data = 0;
        nx(); start = 0;
        for (int i = 1; i < 53; i++) begin cap_data = 12'(tap * 10); nx(); end
        chk("pre_rst_capreq", cap_req, 1);
        chk("pre_rst_sum", res_sum, 320);
        rst = 1; abort = 1;
        nx();
        rst = 0; abort = 0;
        chk("mid_rst", {busy, done, cap_req, res_valid, tap, res_tap, res_pos, res_sum, res_mean}, 64'd0);
        nx();

        // full sweep with start pulse while busy at cycle 20
        start = 1; cap_data = 0;
        nx(); n = 1;
        chk("start_busy", busy, 1);
        chk("start_tap", tap, 2);
        nres = 0; ndone = 0; exp_tap = 2;
        while (n <= 33 * 119 + 5) begin
            start = (n == 20);
            cap_data = 12'(tap * 10);
            if (n == 16) chk("settle_capreq", cap_req, 0);
            if (n == 17) chk("first_capreq", cap_req, 1);
            if (res_valid && res_ready) begin
                chk("sw_tap", res_tap, exp_tap);
                chk("sw_pos", res_pos, pmap(8'(exp_tap)));
                chk("sw_sum", res_sum, 160 * exp_tap);
                chk("sw_mean", res_mean, 10 * exp_tap);
                chk("sw_cycle", n, 33 * (nres + 1));
                nres++; exp_tap++;
            end
            if (done) begin
                ndone++;
                chk("done_cycle", n, 33 * 119 + 1);
                chk("done_busy", busy, 0);
            end
            nx(); n++;
        end
        start = 0;
        chk("sw_nres", nres, 119);
        chk("sw_ndone", ndone, 1);

        // backpressure at tap 10
        start = 1; nx(); start = 0;
        hit = 0;
        for (int i = 0; i < 1000; i++) begin
            cap_data = 12'(tap * 10);
            if (res_valid && tap == 8'd10) begin hit = 1; break; end
            nx();
        end
        chk("bp_reach", hit, 1);
        res_ready = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_fields", {res_tap, res_pos, res_sum, res_mean}, {8'd10, 16'd810, 16'd1600, 12'd100});
            chk("bp_tap", tap, 10);
            chk("bp_capreq", cap_req, 0);
            nx();
        end
        chk("bp_hold_valid", res_valid, 1);
        res_ready = 1;
        nx();
        chk("bp_adv_tap", tap, 11);
        chk("bp_adv_valid", res_valid, 0);
        abort = 1; nx(); abort = 0;
        chk("bp_abort_busy", busy, 0);

        // gapped acks with full-scale data
        cap_data = 12'd4095; res_ready = 0; xf = 0; hit = 0;
        start = 1; nx(); start = 0;
        for (int i = 0; i < 200; i++) begin
            cap_ack = i[0] ? 1'b0 : 1'b1;
            if (res_valid) begin hit = 1; break; end
            if (cap_req && cap_ack) xf++;
            nx();
        end
        chk("gap_reach", hit, 1);
        chk("gap_xfers", xf, 16);
        chk("gap_sum", res_sum, 65520);
        chk("gap_mean", res_mean, 4095);
        abort = 1; nx(); abort = 0;
        chk("gap_abort_valid", res_valid, 0);

        // abort after 7 transfers at tap 5
        cap_ack = 1; res_ready = 1; xf = 0; hit = 0;
        start = 1; nx(); start = 0;
        for (int i = 0; i < 400; i++) begin
            cap_data = 12'(tap * 10);
            if (tap == 8'd5 && cap_req) begin
                if (xf == 7) begin hit = 1; break; end
                xf++;
            end
            nx();
        end
        chk("ab_reach", hit, 1);
        abort = 1; nx(); abort = 0;
        chk("ab_busy", busy, 0);
        chk("ab_capreq", cap_req, 0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin ndone += int'(done); nx(); end
        chk("ab_no_done", ndone, 0);
        chk("ab_tap_kept", tap, 5);

        // randomized fresh sweep against a per-tap sum model
        start = 1; nx(); start = 0;
        chk("rnd_start_tap", tap, 2);
        acc = 0; xf = 0; nres = 0; ndone = 0; exp_tap = 2;
        for (int i = 0; i < 20000 && ndone == 0; i++) begin
            cap_data  = 12'($urandom_range(0, 4095));
            cap_ack   = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 1) != 0);
            if (cap_req && cap_ack) begin acc += cap_data; xf++; end
            if (res_valid && res_ready) begin
                chk("rnd_tap", res_tap, exp_tap);
                chk("rnd_pos", res_pos, pmap(8'(exp_tap)));
                chk("rnd_sum", res_sum, acc);
                chk("rnd_mean", res_mean, acc / 16);
                chk("rnd_xfers", xf, 16);
                acc = 0; xf = 0; nres++; exp_tap++;
            end
            nx();
            if (done) ndone++;
        end
        chk("rnd_nres", nres, 119);
        chk("rnd_done", ndone, 1);
        chk("rnd_idle", busy, 0);

        // start together with abort in IDLE
        start = 1; abort = 1; nx(); start = 0; abort = 0;
        chk("sa_busy", busy, 0);
        nx();
        chk("sa_busy2", busy, 0);

        // single-tap sweep on the second instance
        cap_ack = 1; res_ready = 1; cap_data = 12'd70; hit = 0;
        start2 = 1; nx(); start2 = 0;
        chk("b_tap", tap_b, 7);
        for (int i = 0; i < 100; i++) begin
            if (res_valid_b) begin hit = 1; break; end
            nx();
        end
        chk("b_reach", hit, 1);
        chk("b_fields", {res_tap_b, res_pos_b, res_sum_b, res_mean_b}, {8'd7, 16'd570, 16'd1120, 12'd70});
        nx();
        chk("b_done", done_b, 1);
        chk("b_busy", busy_b, 0);
        nx();
        chk("b_done_pulse", done_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
